// File: rtl/nf_fetch_unit.sv
// nanoFOX instruction fetch stage: owns the PC, runs the req/ack handshake to instruction memory,
// and feeds decode. Define NF_FETCH_SKID_EN to add a one-entry skid buffer behind the output register.
module nf_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_src,
  input  logic [31:0] pc_branch,
  input  logic        stall_if,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_ack,
  input  logic [31:0] instr_rdata,
  output logic [31:0] instr_id,
  output logic [31:0] pc_id,
  output logic        instr_vld
);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_KILL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_pend_q, req_pend_d;
  logic        out_vld_q, out_vld_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        out_free;
  logic        dest_free;
  logic        accept;

`ifdef NF_FETCH_SKID_EN
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
`endif

  // A fresh request is withheld during a redirect so the new target is fetched next cycle
  // instead of a wrong-path address that would have to be killed.
  always_comb begin
    out_free = !out_vld_q || !stall_if;
`ifdef NF_FETCH_SKID_EN
    dest_free = out_free || !skid_vld_q;
`else
    dest_free = out_free;
`endif
    instr_req  = 1'b0;
    instr_addr = pc_q;
    case (state_q)
      ST_FETCH: instr_req = req_pend_q || (dest_free && !pc_src);
      ST_KILL: begin
        instr_req  = 1'b1;
        instr_addr = req_addr_q;
      end
      default: ;
    endcase
    accept = (state_q == ST_FETCH) && instr_req && instr_ack && !pc_src;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = instr_req ? instr_addr : req_addr_q;
    req_pend_d = (state_q == ST_FETCH) && instr_req && !instr_ack && !pc_src;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (pc_src && instr_req && !instr_ack) state_d = ST_KILL;
      ST_KILL:  if (instr_ack) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
    if (pc_src) pc_d = pc_branch;
    else if (accept) pc_d = pc_q + 32'd4;
  end

  // Output register and skid: redirect flushes both; otherwise the skid drains first to keep order.
  always_comb begin
    out_vld_d   = out_vld_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
`ifdef NF_FETCH_SKID_EN
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
`endif
    if (pc_src) begin
      out_vld_d   = 1'b0;
      out_instr_d = NOP_INSTR;
`ifdef NF_FETCH_SKID_EN
      skid_vld_d = 1'b0;
`endif
    end else begin
      if (out_free) begin
`ifdef NF_FETCH_SKID_EN
        if (skid_vld_q) begin
          out_vld_d   = 1'b1;
          out_instr_d = skid_instr_q;
          out_pc_d    = skid_pc_q;
          skid_vld_d  = 1'b0;
        end else
`endif
        if (accept) begin
          out_vld_d   = 1'b1;
          out_instr_d = instr_rdata;
          out_pc_d    = pc_q;
        end else begin
          out_vld_d   = 1'b0;
          out_instr_d = NOP_INSTR;
        end
      end
`ifdef NF_FETCH_SKID_EN
      if (accept && (!out_free || skid_vld_q)) begin
        skid_vld_d   = 1'b1;
        skid_instr_d = instr_rdata;
        skid_pc_d    = pc_q;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      req_pend_q  <= 1'b0;
      out_vld_q   <= 1'b0;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      req_pend_q  <= req_pend_d;
      out_vld_q   <= out_vld_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

`ifdef NF_FETCH_SKID_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_vld_q   <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'h0;
    end else begin
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end
`endif

  assign instr_vld = out_vld_q;
  assign instr_id  = out_instr_q;
  assign pc_id     = out_pc_q;

endmodule

// File: tb/tb_nf_fetch_unit.sv
// Directed bench for nf_fetch_unit: sequential fetch, kill of a stale request, redirect on ack,
// stall hold, PC wrap and reset during an outstanding fetch.
module tb_nf_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] TAG    = 32'hDEAD_0000;
`ifdef NF_FETCH_SKID_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_src = 1'b0;
  logic [31:0] pc_branch = 32'h0;
  logic        stall_if = 1'b0;
  logic        instr_req, instr_ack, instr_vld;
  logic [31:0] instr_addr, instr_rdata, instr_id, pc_id;
  logic        zw = 1'b1;
  logic        ack_man = 1'b0;
  int          errors = 0;
  int          checks = 0;

  // Memory model: zero-wait (ack with req) or manually timed ack; data tagged from the address.
  assign instr_ack   = zw ? instr_req : ack_man;
  assign instr_rdata = instr_addr ^ TAG;

  always #5 clk = ~clk;

  nf_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .pc_src(pc_src), .pc_branch(pc_branch), .stall_if(stall_if),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack),
    .instr_rdata(instr_rdata), .instr_id(instr_id), .pc_id(pc_id), .instr_vld(instr_vld)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; pc_src = 1'b0; stall_if = 1'b0; zw = 1'b1; ack_man = 1'b0;
    #1;
    checks++;
    if ({instr_req, instr_addr, instr_vld, instr_id, pc_id} !== {1'b0, RST_PC, 1'b0, NOP, 32'h0}) begin
      errors++;
      $display("FAIL reset_vals: req=%b addr=%h vld=%b id=%h pc_id=%h", instr_req, instr_addr, instr_vld, instr_id, pc_id);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (instr_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: req=%b expected 0", instr_req);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_sequential();
    logic [31:0] ep;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({instr_req, instr_addr} !== {1'b1, RST_PC + 32'(4 * k)}) begin
        errors++;
        $display("FAIL seq_addr[%0d]: req=%b addr=%h expected addr %h", k, instr_req, instr_addr, RST_PC + 32'(4 * k));
      end
      ep = RST_PC + 32'(4 * (k - 1));
      checks++;
      if (k == 0) begin
        if ({instr_vld, instr_id} !== {1'b0, NOP}) begin
          errors++;
          $display("FAIL seq_out[0]: vld=%b id=%h expected 0/%h", instr_vld, instr_id, NOP);
        end
      end else if ({instr_vld, pc_id, instr_id} !== {1'b1, ep, ep ^ TAG}) begin
        errors++;
        $display("FAIL seq_out[%0d]: vld=%b pc_id=%h id=%h expected pc_id %h", k, instr_vld, pc_id, instr_id, ep);
      end
    end
  endtask

  task automatic test_kill();
    do_reset();
    @(negedge clk); #1;
    @(negedge clk); zw = 1'b0; ack_man = 1'b0; #1;
    checks++;
    if ({instr_req, instr_addr, instr_vld, pc_id} !== {1'b1, 32'h104, 1'b1, 32'h100}) begin
      errors++;
      $display("FAIL kill_start: req=%b addr=%h vld=%b pc_id=%h", instr_req, instr_addr, instr_vld, pc_id);
    end
    @(negedge clk); pc_src = 1'b1; pc_branch = 32'h200; #1;
    checks++;
    if ({instr_req, instr_addr} !== {1'b1, 32'h104}) begin
      errors++;
      $display("FAIL kill_wait1: req=%b addr=%h expected 1/104", instr_req, instr_addr);
    end
    @(negedge clk); pc_src = 1'b0; #1;
    checks++;
    if ({instr_req, instr_addr, instr_vld} !== {1'b1, 32'h104, 1'b0}) begin
      errors++;
      $display("FAIL kill_hold: req=%b addr=%h vld=%b expected 1/104/0", instr_req, instr_addr, instr_vld);
    end
    @(negedge clk); ack_man = 1'b1; #1;
    checks++;
    if ({instr_req, instr_addr} !== {1'b1, 32'h104}) begin
      errors++;
      $display("FAIL kill_ack: req=%b addr=%h expected 1/104", instr_req, instr_addr);
    end
    @(negedge clk); ack_man = 1'b0; zw = 1'b1; #1;
    checks++;
    if ({instr_req, instr_addr, instr_vld} !== {1'b1, 32'h200, 1'b0}) begin
      errors++;
      $display("FAIL kill_newreq: req=%b addr=%h vld=%b expected 1/200/0", instr_req, instr_addr, instr_vld);
    end
    @(negedge clk); #1;
    checks++;
    if ({instr_vld, pc_id, instr_id, instr_addr} !== {1'b1, 32'h200, 32'h200 ^ TAG, 32'h204}) begin
      errors++;
      $display("FAIL kill_first_valid: vld=%b pc_id=%h id=%h addr=%h expected pc_id 200", instr_vld, pc_id, instr_id, instr_addr);
    end
  endtask

  task automatic test_redirect_on_ack();
    do_reset();
    repeat (3) begin @(negedge clk); #1; end
    @(negedge clk); zw = 1'b0; ack_man = 1'b0; #1;
    checks++;
    if ({instr_req, instr_addr, instr_vld, pc_id} !== {1'b1, 32'h10C, 1'b1, 32'h108}) begin
      errors++;
      $display("FAIL rack_pre: req=%b addr=%h vld=%b pc_id=%h", instr_req, instr_addr, instr_vld, pc_id);
    end
    @(negedge clk); pc_src = 1'b1; pc_branch = 32'h300; ack_man = 1'b1; #1;
    checks++;
    if ({instr_req, instr_addr} !== {1'b1, 32'h10C}) begin
      errors++;
      $display("FAIL rack_ack: req=%b addr=%h expected 1/10c", instr_req, instr_addr);
    end
    @(negedge clk); pc_src = 1'b0; ack_man = 1'b0; zw = 1'b1; #1;
    checks++;
    if ({instr_req, instr_addr, instr_vld} !== {1'b1, 32'h300, 1'b0}) begin
      errors++;
      $display("FAIL rack_next: req=%b addr=%h vld=%b expected 1/300/0", instr_req, instr_addr, instr_vld);
    end
    @(negedge clk); #1;
    checks++;
    if ({instr_vld, pc_id} !== {1'b1, 32'h300}) begin
      errors++;
      $display("FAIL rack_valid: vld=%b pc_id=%h expected 1/300", instr_vld, pc_id);
    end
  endtask

  task automatic test_stall();
    int n_extra;
    n_extra = 0;
    do_reset();
    @(negedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); stall_if = 1'b1; #1;
      if (instr_req && instr_ack) n_extra++;
      checks++;
      if ({instr_vld, pc_id, instr_id} !== {1'b1, 32'h100, 32'h100 ^ TAG}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: vld=%b pc_id=%h id=%h expected 1/100", c, instr_vld, pc_id, instr_id);
      end
    end
    checks++;
    if (n_extra !== EXTRA) begin
      errors++;
      $display("FAIL stall_extra_fetch: got %0d expected %0d", n_extra, EXTRA);
    end
    @(negedge clk); stall_if = 1'b0; #1;
    checks++;
    if ({instr_req, instr_addr, pc_id} !== {1'b1, 32'h104 + 32'(4 * EXTRA), 32'h100}) begin
      errors++;
      $display("FAIL stall_release: req=%b addr=%h pc_id=%h", instr_req, instr_addr, pc_id);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({instr_vld, pc_id} !== {1'b1, 32'h100 + 32'(4 * c)}) begin
        errors++;
        $display("FAIL stall_after[%0d]: vld=%b pc_id=%h expected %h", c, instr_vld, pc_id, 32'h100 + 32'(4 * c));
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk); #1;
    @(negedge clk); pc_src = 1'b1; pc_branch = 32'hFFFF_FFFC; #1;
    @(negedge clk); pc_src = 1'b0; #1;
    checks++;
    if ({instr_req, instr_addr, instr_vld} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
      errors++;
      $display("FAIL wrap_target: req=%b addr=%h vld=%b", instr_req, instr_addr, instr_vld);
    end
    @(negedge clk); #1;
    checks++;
    if ({instr_addr, instr_vld, pc_id} !== {32'h0, 1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_zero: addr=%h vld=%b pc_id=%h expected 0/1/fffffffc", instr_addr, instr_vld, pc_id);
    end
    @(negedge clk); #1;
    checks++;
    if ({instr_addr, pc_id} !== {32'h4, 32'h0}) begin
      errors++;
      $display("FAIL wrap_next: addr=%h pc_id=%h expected 4/0", instr_addr, pc_id);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (2) begin @(negedge clk); #1; end
    @(negedge clk); zw = 1'b0; ack_man = 1'b0; #1;
    checks++;
    if ({instr_req, instr_addr, instr_vld, pc_id} !== {1'b1, 32'h108, 1'b1, 32'h104}) begin
      errors++;
      $display("FAIL rmid_pre: req=%b addr=%h vld=%b pc_id=%h", instr_req, instr_addr, instr_vld, pc_id);
    end
    @(negedge clk); reset = 1'b1; #1;
    checks++;
    if ({instr_req, instr_addr, instr_vld, instr_id, pc_id} !== {1'b0, RST_PC, 1'b0, NOP, 32'h0}) begin
      errors++;
      $display("FAIL rmid_reset: req=%b addr=%h vld=%b id=%h pc_id=%h", instr_req, instr_addr, instr_vld, instr_id, pc_id);
    end
    @(negedge clk); reset = 1'b0; zw = 1'b1; #1;
    checks++;
    if (instr_req !== 1'b0) begin
      errors++;
      $display("FAIL rmid_idle: req=%b expected 0", instr_req);
    end
    @(negedge clk); #1;
    checks++;
    if ({instr_req, instr_addr} !== {1'b1, RST_PC}) begin
      errors++;
      $display("FAIL rmid_restart: req=%b addr=%h expected 1/%h", instr_req, instr_addr, RST_PC);
    end
    @(negedge clk); #1;
    checks++;
    if ({instr_vld, pc_id} !== {1'b1, RST_PC}) begin
      errors++;
      $display("FAIL rmid_valid: vld=%b pc_id=%h expected 1/%h", instr_vld, pc_id, RST_PC);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_kill();
    test_redirect_on_ack();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
